// File: rtl/euros_pa_centimos.sv
// euros_pa_centimos
//  Converts a euro amount (whole euros + cents fraction) into a total count of
//  cents: centimos = euros_inteiro*100 + eurosfracao. The multiply by 100 is a
//  serial shift-add over the 7 bits of 100, so one conversion takes 9 cycles.
//
// Ports
//  clk            clock, all logic on the rising edge
//  rst            synchronous active-high reset, aborts any conversion
//  in_valid       euros_inteiro/eurosfracao are valid
//  in_ready       block can accept a new amount (high only while idle)
//  euros_inteiro  whole euros
//  eurosfracao    cents fraction, legal range 0..99
//  out_valid      centimos/erro are valid, held until out_ready
//  out_ready      consumer takes the result
//  centimos       converted amount in cents
//  erro           illegal fraction, or result above MAX_CENT
//
// Build option
//  EUROS_OVF_SAT_EN  when defined, an overflowing result reports MAX_CENT
//                    instead of 0 (erro is raised in both builds).

module euros_pa_centimos #(
  parameter int W        = 14,
  parameter int MAX_CENT = 9999
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] euros_inteiro,
  input  logic [W-1:0] eurosfracao,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] centimos,
  output logic         erro
);

  // Accumulator is wide enough for (2**W-1)*100 + 99, so nothing wraps.
  localparam int AW = W + 7;

  // 100 = 7'b1100100; bit idx selects whether euros<<idx is added.
  localparam logic [6:0] MULT = 7'b1100100;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] ADD  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [W-1:0]  euros_reg;
  logic [W-1:0]  frac_reg;
  logic [AW-1:0] acc;
  logic [2:0]    idx;

  logic [AW-1:0] partial;
  logic [AW-1:0] sum;
  logic          frac_bad;
  logic          overflow;

  assign partial  = {{7{1'b0}}, euros_reg} << idx;
  assign sum      = acc + {{7{1'b0}}, frac_reg};
  assign frac_bad = (frac_reg >= W'(100));
  assign overflow = (sum > AW'(MAX_CENT));
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      euros_reg <= '0;
      frac_reg  <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      centimos  <= '0;
      erro      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            euros_reg <= euros_inteiro;
            frac_reg  <= eurosfracao;
            acc       <= '0;
            idx       <= '0;
            state     <= MUL;
          end
        end

        MUL: begin
          if (MULT[idx]) begin
            acc <= acc + partial;
          end
          idx <= idx + 3'd1;
          if (idx == 3'd6) begin
            state <= ADD;
          end
        end

        ADD: begin
          out_valid <= 1'b1;
          state     <= DONE;
          if (frac_bad) begin
            // An illegal fraction takes priority and always reports 0.
            erro     <= 1'b1;
            centimos <= '0;
          end else if (overflow) begin
            erro     <= 1'b1;
`ifdef EUROS_OVF_SAT_EN
            centimos <= W'(MAX_CENT);
`else
            centimos <= '0;
`endif
          end else begin
            erro     <= 1'b0;
            centimos <= sum[W-1:0];
          end
        end

        DONE: begin
          // Result is held until taken; the next accept is a cycle later.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
